// File: rtl/pixel_stream_pkg.sv
// Shared constants, FSM encoding and sizing helper for the pixel packer.
//   BYTES_PER_PIXEL / BYTES_PER_WORD : packing ratio (4 pixels -> 3 words)
//   pack_state_e                     : PACK (accepting pixels), FLUSH (emit pad word)
//   words_per_line()                 : ceil(3*pixels/4), output words per line
package pixel_stream_pkg;
  localparam int unsigned BYTES_PER_PIXEL = 3;
  localparam int unsigned BYTES_PER_WORD  = 4;

  typedef enum logic {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } pack_state_e;

  function automatic int unsigned words_per_line(input int unsigned pixels);
    return (pixels * BYTES_PER_PIXEL + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
  endfunction
endpackage

// File: rtl/axis_pixel_packer_if.sv
// Pixel-in / packed-word-out bus of the pixel packer.
//   s_pix_*    : 24-bit RGB pixel stream into the packer
//   m00_axis_* : 32-bit packed AXI-Stream toward the upsampler
// Modports: master = the packer (AXIS master of m00), slave = its environment.
// m00_axis_tuser exists only when FRAME_TUSER_EN is defined.
interface axis_pixel_packer_if #(
  parameter int PIXEL_WIDTH = 24,
  parameter int TDATA_WIDTH = 32
);
  logic                   s_pix_valid;
  logic                   s_pix_ready;
  logic [PIXEL_WIDTH-1:0] s_pix_data;
  logic                   m00_axis_tvalid;
  logic                   m00_axis_tready;
  logic [TDATA_WIDTH-1:0] m00_axis_tdata;
  logic                   m00_axis_tlast;
`ifdef FRAME_TUSER_EN
  logic                   m00_axis_tuser;
`endif

  modport master (
    input  s_pix_valid, s_pix_data, m00_axis_tready,
`ifdef FRAME_TUSER_EN
    output m00_axis_tuser,
`endif
    output s_pix_ready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast
  );

  modport slave (
    output s_pix_valid, s_pix_data, m00_axis_tready,
`ifdef FRAME_TUSER_EN
    input  m00_axis_tuser,
`endif
    input  s_pix_ready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast
  );
endinterface

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register.
//   load/ld_*  : new word to present; caller only loads when free=1
//   free       : register empty or being drained this cycle
//   tvalid/tready/tdata/tlast(/tuser) : AXIS master side
// Contents change only on load, and load is only taken when free, so
// data/last/user stay put while tvalid=1 and tready=0.
// tuser ports exist only when FRAME_TUSER_EN is defined.
module axis_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
`ifdef FRAME_TUSER_EN
  input  logic              ld_user,
  output logic              tuser,
`endif
  output logic              free,
  output logic              tvalid,
  input  logic              tready,
  output logic [DATA_W-1:0] tdata,
  output logic              tlast
);
  assign free = !tvalid || tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tlast  <= 1'b0;
`ifdef FRAME_TUSER_EN
      tuser  <= 1'b0;
`endif
    end else if (load) begin
      // Drain and reload in the same cycle: no bubble.
      tvalid <= 1'b1;
      tdata  <= ld_data;
      tlast  <= ld_last;
`ifdef FRAME_TUSER_EN
      tuser  <= ld_user;
`endif
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end
endmodule

// File: rtl/axis_pixel_packer.sv
// Packs 24-bit RGB pixels into little-endian 32-bit AXIS words (4 px -> 3 words).
//   clk, rst_n : single clock, synchronous active-low reset
//   bus        : axis_pixel_packer_if.master (s_pix_* in, m00_axis_* out)
// Stream byte k lands in tdata[8*(k%4) +: 8]. tlast marks the final word of a
// line; a line whose byte count is not a multiple of 4 ends with a zero-padded
// word emitted from the FLUSH state.
// Optional: FRAME_TUSER_EN adds m00_axis_tuser (first word of line 0 of each
// frame) together with the FRAME_LINES parameter and line counter.
module axis_pixel_packer
  import pixel_stream_pkg::*;
#(
  parameter int PIXEL_WIDTH            = 24,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
`ifdef FRAME_TUSER_EN
  parameter int FRAME_LINES            = 2160,
`endif
  parameter int LINE_PIXELS            = 3840
) (
  input logic                 clk,
  input logic                 rst_n,
  axis_pixel_packer_if.master bus
);
  localparam int          WORD_W   = C_M00_AXIS_TDATA_WIDTH;
  localparam int          RES_W    = PIXEL_WIDTH;      // residual: up to 3 bytes
  localparam int          BUF_W    = 2 * PIXEL_WIDTH;  // residual + new pixel
  localparam logic [15:0] LAST_PIX = 16'(LINE_PIXELS - 1);

  pack_state_e        state_q, state_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [1:0]         res_cnt_q, res_cnt_d;
  logic [15:0]        pix_cnt_q, pix_cnt_d;
  logic               s_ready, accept, last_pix, out_free;
  logic               load, ld_last;
  logic [WORD_W-1:0]  ld_data;
  logic [2:0]         avail;
  logic [BUF_W-1:0]   merged;

  // rst_n gate keeps ready low while reset is held.
  assign s_ready         = rst_n && (state_q == PACK) && out_free;
  assign bus.s_pix_ready = s_ready;
  assign accept          = bus.s_pix_valid && s_ready;
  assign last_pix        = (pix_cnt_q == LAST_PIX);
  assign avail           = {1'b0, res_cnt_q} + 3'(BYTES_PER_PIXEL);
  // Residual bytes sit at the bottom with zeros above them, so OR-ing the
  // shifted pixel in yields the byte stream in order.
  assign merged          = BUF_W'(res_q) | (BUF_W'(bus.s_pix_data) << {res_cnt_q, 3'b000});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= PACK;
      res_q     <= '0;
      res_cnt_q <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      res_cnt_q <= res_cnt_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    res_cnt_d = res_cnt_q;
    pix_cnt_d = pix_cnt_q;
    load      = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    case (state_q)
      PACK: begin
        if (accept) begin
          pix_cnt_d = last_pix ? '0 : pix_cnt_q + 16'd1;
          if (avail >= 3'(BYTES_PER_WORD)) begin
            load      = 1'b1;
            ld_data   = merged[WORD_W-1:0];
            res_d     = RES_W'(merged[BUF_W-1:WORD_W]);
            res_cnt_d = 2'(avail - 3'(BYTES_PER_WORD));
            // tlast here only on an exact fit; otherwise the pad word carries it.
            ld_last   = last_pix && (avail == 3'(BYTES_PER_WORD));
          end else begin
            res_d     = merged[RES_W-1:0];
            res_cnt_d = 2'(avail);
          end
          if (last_pix && (res_cnt_d != 2'd0)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_free) begin
          load      = 1'b1;
          ld_data   = WORD_W'(res_q);  // upper bytes already zero
          ld_last   = 1'b1;
          res_d     = '0;
          res_cnt_d = '0;
          state_d   = PACK;
        end
      end
      default: state_d = PACK;
    endcase
  end

`ifdef FRAME_TUSER_EN
  localparam logic [15:0] LAST_LINE = 16'(FRAME_LINES - 1);
  logic [15:0] line_cnt_q;
  logic        first_word_q;
  logic        ld_user;

  // A line ends when its tlast word is loaded; the next word loaded opens a line.
  assign ld_user = first_word_q && (line_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_cnt_q   <= '0;
      first_word_q <= 1'b1;
    end else if (load) begin
      first_word_q <= ld_last;
      if (ld_last) line_cnt_q <= (line_cnt_q == LAST_LINE) ? '0 : line_cnt_q + 16'd1;
    end
  end
`endif

  axis_out_reg #(.DATA_W(WORD_W)) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .ld_data (ld_data),
    .ld_last (ld_last),
`ifdef FRAME_TUSER_EN
    .ld_user (ld_user),
    .tuser   (bus.m00_axis_tuser),
`endif
    .free    (out_free),
    .tvalid  (bus.m00_axis_tvalid),
    .tready  (bus.m00_axis_tready),
    .tdata   (bus.m00_axis_tdata),
    .tlast   (bus.m00_axis_tlast)
  );
endmodule

// File: tb/tb_axis_pixel_packer.sv
// Four packers (LINE_PIXELS = 4, 1, 5, 6) driven by directed vectors; expected
// words are queued per instance and popped by a monitor on every handshake.
module tb_axis_pixel_packer;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        user;
  } exp_t;

  localparam int LPS [4] = '{4, 1, 5, 6};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             rst_n;
  logic [3:0]       pv, tr, sr, ov, ol;
  logic [3:0][23:0] pd;
  logic [3:0][31:0] od;
`ifdef FRAME_TUSER_EN
  logic [3:0]       ou;
`endif
  exp_t exp_q [4][$];
  int   hs0 [$];
  int   words [4];
  int   checks, errors;
  logic tog;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    axis_pixel_packer_if #(.PIXEL_WIDTH(24), .TDATA_WIDTH(32)) bus ();
    assign bus.s_pix_valid     = pv[g];
    assign bus.s_pix_data      = pd[g];
    assign bus.m00_axis_tready = tr[g];
    assign sr[g] = bus.s_pix_ready;
    assign ov[g] = bus.m00_axis_tvalid;
    assign od[g] = bus.m00_axis_tdata;
    assign ol[g] = bus.m00_axis_tlast;
`ifdef FRAME_TUSER_EN
    assign ou[g] = bus.m00_axis_tuser;
`endif
    axis_pixel_packer #(
      .PIXEL_WIDTH            (24),
      .C_M00_AXIS_TDATA_WIDTH (32),
`ifdef FRAME_TUSER_EN
      .FRAME_LINES            (2),
`endif
      .LINE_PIXELS            (LPS[g])
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
    );
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic push(input int i, input logic [31:0] d, input logic l, input logic u);
    exp_t e;
    e.data = d; e.last = l; e.user = u;
    exp_q[i].push_back(e);
  endtask

  // Present a pixel at the negedge; it is accepted at the next posedge once ready.
  task automatic send(input int i, input logic [23:0] d);
    int n = 0;
    @(negedge clk);
    pv[i] = 1'b1;
    pd[i] = d;
    #1;
    while (!sr[i] && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!sr[i]) begin
      checks++; errors++;
      $display("FAIL send_timeout dut%0d: got ready=0 expected ready=1", i);
    end
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    pv[i] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
           && n < 400) begin
      @(negedge clk); n++;
    end
    checks++;
    if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d/%0d/%0d pending expected 0", exp_q[0].size(),
               exp_q[1].size(), exp_q[2].size(), exp_q[3].size());
    end
  endtask

  task automatic toggler();
    tr = 4'hF;
    forever begin
      @(negedge clk);
      if (tog) tr[3] = ~tr[3];
      else     tr    = 4'hF;
    end
  endtask

  task automatic monitor();
    exp_t             e;
    logic [3:0]       stall_prev = '0;
    logic [3:0][31:0] hd;
    logic [3:0]       hl;
    forever begin
      @(negedge clk); #2;
      for (int i = 0; i < 4; i++) begin
        if (stall_prev[i] && rst_n) begin
          checks++;
          if (ov[i] !== 1'b1 || od[i] !== hd[i] || ol[i] !== hl[i]) begin
            errors++;
            $display("FAIL stall_hold dut%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                     i, ov[i], od[i], ol[i], hd[i], hl[i]);
          end
        end
        stall_prev[i] = rst_n && ov[i] && !tr[i];
        hd[i] = od[i];
        hl[i] = ol[i];
        if (rst_n && ov[i] && tr[i]) begin
          words[i]++;
          if (i == 0) hs0.push_back(cyc);
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL unexpected_word dut%0d: got %h expected no word", i, od[i]);
          end else begin
            e = exp_q[i].pop_front();
            if (od[i] !== e.data || ol[i] !== e.last
`ifdef FRAME_TUSER_EN
                || ou[i] !== e.user
`endif
               ) begin
              errors++;
              $display("FAIL word dut%0d: got d=%h l=%b expected d=%h l=%b u=%b",
                       i, od[i], ol[i], e.data, e.last, e.user);
            end
          end
        end
      end
    end
  endtask

  // One 6-pixel line: bytes 0x40+18*L+k; 5 words, the last holding 2 bytes + pad.
  task automatic lp6_line(input int L);
    logic [7:0]  b [20];
    logic [31:0] w;
    for (int k = 0; k < 20; k++) b[k] = (k < 18) ? 8'(8'h40 + 18 * L + k) : 8'h00;
    for (int n = 0; n < 5; n++) begin
      w = {b[4*n+3], b[4*n+2], b[4*n+1], b[4*n]};
      push(3, w, n == 4, (n == 0) && (L % 2 == 0));
    end
    for (int j = 0; j < 6; j++) send(3, {b[3*j+2], b[3*j+1], b[3*j]});
  endtask

  task automatic lp4_std_line(input logic u);
    push(0, 32'h33221100, 1'b0, u);
    push(0, 32'h77665544, 1'b0, 1'b0);
    push(0, 32'hBBAA9988, 1'b1, 1'b0);
    send(0, 24'h221100); send(0, 24'h554433); send(0, 24'h887766); send(0, 24'hBBAA99);
  endtask

  initial begin
    rst_n = 1'b0; pv = '0; pd = '0; tog = 1'b0; checks = 0; errors = 0;
    for (int i = 0; i < 4; i++) words[i] = 0;
    fork
      monitor();
      toggler();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_ctl_dut%0d", i), {29'd0, ov[i], ol[i], sr[i]}, 32'd0);
      chk($sformatf("reset_data_dut%0d", i), od[i], 32'd0);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    for (int i = 0; i < 4; i++) chk($sformatf("ready_after_reset_dut%0d", i), {31'd0, sr[i]}, 32'd1);

    // LINE_PIXELS=4, exact fit, back-to-back words
    lp4_std_line(1'b1);
    idle(0);
    drain();
    if (hs0.size() < 3) begin
      checks++; errors++;
      $display("FAIL throughput_count: got %0d words expected 3", hs0.size());
    end else begin
      chk("throughput_gap1", 32'(hs0[1] - hs0[0]), 32'd1);
      chk("throughput_gap2", 32'(hs0[2] - hs0[1]), 32'd1);
    end

    // LINE_PIXELS=1, every line goes through FLUSH
    push(1, 32'h00123456, 1'b1, 1'b1);
    send(1, 24'h123456);
    idle(1); #1;
    chk("flush_ready_low", {31'd0, sr[1]}, 32'd0);
    push(1, 32'h00ABCDEF, 1'b1, 1'b0);
    send(1, 24'hABCDEF);
    idle(1);
    drain();

    // LINE_PIXELS=5, partial line with pad byte, then a byte-aligned second line
    push(2, 32'h03020100, 1'b0, 1'b1);
    push(2, 32'h07060504, 1'b0, 1'b0);
    push(2, 32'h0B0A0908, 1'b0, 1'b0);
    push(2, 32'h000E0D0C, 1'b1, 1'b0);
    send(2, 24'h020100); send(2, 24'h050403); send(2, 24'h080706);
    send(2, 24'h0B0A09); send(2, 24'h0E0D0C);
    push(2, 32'h1211100F, 1'b0, 1'b0);
    push(2, 32'h16151413, 1'b0, 1'b0);
    push(2, 32'h1A191817, 1'b0, 1'b0);
    push(2, 32'h001D1C1B, 1'b1, 1'b0);
    send(2, 24'h11100F); send(2, 24'h141312); send(2, 24'h171615);
    send(2, 24'h1A1918); send(2, 24'h1D1C1B);
    idle(2);
    drain();

    // LINE_PIXELS=6 with tready toggling every cycle
    tog = 1'b1;
    for (int L = 0; L < 3; L++) lp6_line(L);
    idle(3);
    drain();
    tog = 1'b0;

    // Reset mid-line on LINE_PIXELS=4: held word and residual bytes dropped
    send(0, 24'h030201);
    send(0, 24'h060504);
    @(negedge clk);
    pv[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_tvalid", {31'd0, ov[0]}, 32'd0);
    push(0, 32'hBBAAAAAA, 1'b0, 1'b1);
    push(0, 32'hCCCCBBBB, 1'b0, 1'b0);
    push(0, 32'hDDDDDDCC, 1'b1, 1'b0);
    send(0, 24'hAAAAAA); send(0, 24'hBBBBBB); send(0, 24'hCCCCCC); send(0, 24'hDDDDDD);
    lp4_std_line(1'b0);
    lp4_std_line(1'b1);
    idle(0);
    drain();
    repeat (4) @(negedge clk);

    chk("words_dut0", 32'(words[0]), 32'd12);
    chk("words_dut1", 32'(words[1]), 32'd2);
    chk("words_dut2", 32'(words[2]), 32'd8);
    chk("words_dut3", 32'(words[3]), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
